// File: rtl/sram_arb.sv
// sram_arb: arbiter and strobe sequencer for the shared 32-bit external SRAM.
//
// There are three requesters:
//   - video: read-only, strict priority
//   - CPU:   word or byte, read or write
//   - DMA:   word, read or write
// CPU and DMA share the bus round-robin.
//
// Each access is sequenced into SRAM strobe cycles:
//   - read:  RD
//   - write: WR1 (drive data), WR2 (write strobe), then a mandatory IDLE
//            turnaround cycle.
// All SRAM-side outputs and all acknowledge/data outputs are registered.

module sram_arb (
    input  logic        clk,
    input  logic        rst,

    // video refresh port (read-only)
    input  logic        vreq,
    input  logic [17:0] vadr,
    output logic        vack,
    output logic [31:0] vdata,

    // CPU port (byte address, word or byte access)
    input  logic        crd,
    input  logic        cwr,
    input  logic        cben,
    input  logic [19:0] cadr,
    input  logic [31:0] cwdata,
    output logic [31:0] crdata,
    output logic        cack,
    output logic        cstall,

    // DMA port (word address)
    input  logic        dreq,
    input  logic        dwr,
    input  logic [17:0] dadr,
    input  logic [31:0] dwdata,
    output logic [31:0] drdata,
    output logic        dack,

    // SRAM pads
    output logic [17:0] sr_adr,
    output logic        sr_oe_n,
    output logic        sr_we_n,
    output logic [3:0]  sr_be_n,
    output logic [31:0] sr_dout,
    output logic        sr_dout_en,
    input  logic [31:0] sr_din
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR1,
        S_WR2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VID,
        OWN_CPU,
        OWN_DMA
    } owner_t;

    state_t     state;
    owner_t     owner;      // requester that owns the access in flight
    logic       last_dma;   // 1: DMA won the last CPU/DMA grant, so CPU is favoured
    logic       byte_rd;    // access in flight is a CPU byte read
    logic [1:0] byte_lane;  // lane selected by the CPU byte access in flight

    // Arbitration results, valid only on edges leaving IDLE or RD
    logic       arb_en;
    logic       mask_v;
    logic       mask_c;
    logic       mask_d;
    logic       v_req;
    logic       c_req;
    logic       d_req;
    owner_t     gnt;
    logic       gnt_wr;
    logic [17:0] gnt_adr;
    logic [3:0]  gnt_be_n;
    logic [31:0] gnt_dout;
    logic [7:0]  rd_byte;

    // The CPU is stalled from the moment it asks until its ack cycle
    assign cstall = (crd | cwr) & ~cack;

    // A read that finishes at this edge still sees its request high,
    // so its owner is kept out of this one arbitration.
    assign arb_en = (state == S_IDLE) || (state == S_RD);
    assign mask_v = (state == S_RD) && (owner == OWN_VID);
    assign mask_c = (state == S_RD) && (owner == OWN_CPU);
    assign mask_d = (state == S_RD) && (owner == OWN_DMA);

    assign v_req = vreq & ~mask_v;
    assign c_req = (crd | cwr) & ~mask_c;
    assign d_req = dreq & ~mask_d;

    // Pick the next owner: video first, then CPU/DMA by round-robin
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        gnt      = OWN_NONE;
        gnt_wr   = 1'b0;
        gnt_adr  = sr_adr;
        gnt_be_n = 4'b1111;
        gnt_dout = sr_dout;
        if (arb_en) begin
            if (v_req) begin
                gnt      = OWN_VID;
                gnt_adr  = vadr;
                gnt_be_n = 4'b0000;
            end else if (c_req && (!d_req || last_dma)) begin
                gnt      = OWN_CPU;
                gnt_wr   = cwr;
                gnt_adr  = cadr[19:2];
                if (cben) begin
                    // only the addressed lane is strobed; the byte is
                    // replicated so any lane carries it
                    gnt_be_n = ~(4'b0001 << cadr[1:0]);
                    gnt_dout = {4{cwdata[7:0]}};
                end else begin
                    gnt_be_n = 4'b0000;
                    gnt_dout = cwdata;
                end
            end else if (d_req) begin
                gnt      = OWN_DMA;
                gnt_wr   = dwr;
                gnt_adr  = dadr;
                gnt_be_n = 4'b0000;
                gnt_dout = dwdata;
            end
        end
    end

    // Select the byte lane returned by a CPU byte read
    always_comb begin
        case (byte_lane)
            2'd0:    rd_byte = sr_din[7:0];
            2'd1:    rd_byte = sr_din[15:8];
            2'd2:    rd_byte = sr_din[23:16];
            default: rd_byte = sr_din[31:24];
        endcase
    end

    // Access sequencer: state, grants, strobes, acks and read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            owner      <= OWN_NONE;
            last_dma   <= 1'b1;
            byte_rd    <= 1'b0;
            byte_lane  <= 2'd0;
            sr_adr     <= 18'd0;
            sr_oe_n    <= 1'b1;
            sr_we_n    <= 1'b1;
            sr_be_n    <= 4'b1111;
            sr_dout    <= 32'd0;
            sr_dout_en <= 1'b0;
            vack       <= 1'b0;
            cack       <= 1'b0;
            dack       <= 1'b0;
            vdata      <= 32'd0;
            crdata     <= 32'd0;
            drdata     <= 32'd0;
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every
            // read of state, owner or sr_* below sees the pre-edge value.
            vack <= 1'b0;
            cack <= 1'b0;
            dack <= 1'b0;

            // Completion of the access in flight
            if (state == S_RD) begin
                case (owner)
                    OWN_VID: begin
                        vdata <= sr_din;
                        vack  <= 1'b1;
                    end
                    OWN_CPU: begin
                        crdata <= byte_rd ? {24'd0, rd_byte} : sr_din;
                        cack   <= 1'b1;
                    end
                    OWN_DMA: begin
                        drdata <= sr_din;
                        dack   <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (state == S_WR2) begin
                case (owner)
                    OWN_CPU: cack <= 1'b1;
                    OWN_DMA: dack <= 1'b1;
                    default: ;
                endcase
            end

            case (state)
                S_IDLE, S_RD: begin
                    if (gnt != OWN_NONE) begin
                        owner     <= gnt;
                        sr_adr    <= gnt_adr;
                        sr_be_n   <= gnt_be_n;
                        sr_dout   <= gnt_dout;
                        byte_rd   <= (gnt == OWN_CPU) && cben && !gnt_wr;
                        byte_lane <= cadr[1:0];
                        if (gnt == OWN_CPU) begin
                            last_dma <= 1'b0;
                        end else if (gnt == OWN_DMA) begin
                            last_dma <= 1'b1;
                        end
                        if (gnt_wr) begin
                            state      <= S_WR1;
                            sr_oe_n    <= 1'b1;
                            sr_we_n    <= 1'b1;
                            sr_dout_en <= 1'b1;
                        end else begin
                            state      <= S_RD;
                            sr_oe_n    <= 1'b0;
                            sr_we_n    <= 1'b1;
                            sr_dout_en <= 1'b0;
                        end
                    end else begin
                        state      <= S_IDLE;
                        owner      <= OWN_NONE;
                        sr_oe_n    <= 1'b1;
                        sr_we_n    <= 1'b1;
                        sr_be_n    <= 4'b1111;
                        sr_dout_en <= 1'b0;
                    end
                end
                S_WR1: begin
                    // data has been on the pads for a full cycle; strobe now
                    state   <= S_WR2;
                    sr_we_n <= 1'b0;
                end
                S_WR2: begin
                    // always pass through IDLE so the pads turn around
                    state      <= S_IDLE;
                    owner      <= OWN_NONE;
                    sr_we_n    <= 1'b1;
                    sr_dout_en <= 1'b0;
                    sr_be_n    <= 4'b1111;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: self-checking bench for sram_arb with an SRAM pad model and a
// transaction-level reference memory.
`timescale 1ns/1ps

module tb_sram_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vreq = 1'b0;
    logic [17:0] vadr = '0;
    logic        vack;
    logic [31:0] vdata;
    logic        crd = 1'b0;
    logic        cwr = 1'b0;
    logic        cben = 1'b0;
    logic [19:0] cadr = '0;
    logic [31:0] cwdata = '0;
    logic [31:0] crdata;
    logic        cack;
    logic        cstall;
    logic        dreq = 1'b0;
    logic        dwr = 1'b0;
    logic [17:0] dadr = '0;
    logic [31:0] dwdata = '0;
    logic [31:0] drdata;
    logic        dack;
    logic [17:0] sr_adr;
    logic        sr_oe_n;
    logic        sr_we_n;
    logic [3:0]  sr_be_n;
    logic [31:0] sr_dout;
    logic        sr_dout_en;
    logic [31:0] sr_din;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_tick = 0;
    bit fav_cpu = 1'b1;   // reference round-robin: CPU wins the next tie

    logic [31:0] sram    [int];   // contents of the external chip
    logic [31:0] exp_mem [int];   // what the bench expects the chip to hold

    sram_arb dut (
        .clk(clk), .rst(rst),
        .vreq(vreq), .vadr(vadr), .vack(vack), .vdata(vdata),
        .crd(crd), .cwr(cwr), .cben(cben), .cadr(cadr), .cwdata(cwdata),
        .crdata(crdata), .cack(cack), .cstall(cstall),
        .dreq(dreq), .dwr(dwr), .dadr(dadr), .dwdata(dwdata),
        .drdata(drdata), .dack(dack),
        .sr_adr(sr_adr), .sr_oe_n(sr_oe_n), .sr_we_n(sr_we_n), .sr_be_n(sr_be_n),
        .sr_dout(sr_dout), .sr_dout_en(sr_dout_en), .sr_din(sr_din)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] sram_word(input int a);
        return sram.exists(a) ? sram[a] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_rd(input int a);
        return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
    endfunction

    function automatic void exp_wr_word(input int a, input logic [31:0] d);
        exp_mem[a] = d;
    endfunction

    function automatic void exp_wr_byte(input int a, input int lane, input logic [7:0] b);
        logic [31:0] w;
        w = exp_rd(a);
        w[lane*8 +: 8] = b;
        exp_mem[a] = w;
    endfunction

    function automatic logic [31:0] exp_cpu_rd(input int a, input bit ben, input int lane);
        logic [31:0] w;
        w = exp_rd(a);
        return ben ? {24'd0, w[lane*8 +: 8]} : w;
    endfunction

    // asynchronous SRAM: drives data while OE is low, writes enabled lanes under WE
    always @(sr_oe_n, sr_adr, wr_tick) sr_din = sr_oe_n ? 32'h0 : sram_word(int'(sr_adr));

    always @(posedge clk) begin
        if (!sr_we_n && sr_dout_en) begin
            logic [31:0] w;
            w = sram_word(int'(sr_adr));
            for (int l = 0; l < 4; l++) if (!sr_be_n[l]) w[l*8 +: 8] = sr_dout[l*8 +: 8];
            sram[int'(sr_adr)] = w;
            wr_tick++;
        end
    end

    // ---------------- port drivers (entered just after a falling edge) -----
    task automatic cpu_xfer(input bit wr, input bit ben, input logic [19:0] adr,
                            input logic [31:0] wd, output logic [31:0] rd, output int ack_cyc);
        crd = !wr; cwr = wr; cben = ben; cadr = adr; cwdata = wd;
        ack_cyc = -1; rd = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cack) begin ack_cyc = cyc; rd = crdata; break; end
        end
        crd = 1'b0; cwr = 1'b0; cben = 1'b0;
    endtask

    task automatic vid_xfer(input logic [17:0] adr, output logic [31:0] rd, output int ack_cyc);
        vreq = 1'b1; vadr = adr;
        ack_cyc = -1; rd = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (vack) begin ack_cyc = cyc; rd = vdata; break; end
        end
        vreq = 1'b0;
    endtask

    task automatic dma_xfer(input bit wr, input logic [17:0] adr, input logic [31:0] wd,
                            output logic [31:0] rd, output int ack_cyc);
        dreq = 1'b1; dwr = wr; dadr = adr; dwdata = wd;
        ack_cyc = -1; rd = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dack) begin ack_cyc = cyc; rd = drdata; break; end
        end
        dreq = 1'b0; dwr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        fav_cpu = 1'b1;
    endtask

    // ---------------- scenarios --------------------------------------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (sr_oe_n !== 1'b1) begin errors++; $display("FAIL rst_oe_n got %b exp 1", sr_oe_n); end
        checks++; if (sr_we_n !== 1'b1) begin errors++; $display("FAIL rst_we_n got %b exp 1", sr_we_n); end
        checks++; if (sr_be_n !== 4'hF) begin errors++; $display("FAIL rst_be_n got %h exp f", sr_be_n); end
        checks++; if (sr_dout_en !== 1'b0) begin errors++; $display("FAIL rst_dout_en got %b exp 0", sr_dout_en); end
        checks++; if (sr_adr !== 18'd0) begin errors++; $display("FAIL rst_adr got %h exp 0", sr_adr); end
        checks++; if ({vack, cack, dack} !== 3'b000) begin errors++; $display("FAIL rst_acks got %b exp 000", {vack, cack, dack}); end
        checks++; if ({vdata, crdata, drdata} !== 96'd0) begin errors++; $display("FAIL rst_data got %h exp 0", {vdata, crdata, drdata}); end
        @(negedge clk); rst = 1'b1;
        fav_cpu = 1'b1;
    endtask

    task automatic test_cpu_word();
        logic [31:0] rd; int s, ack;
        @(negedge clk);
        cwr = 1'b1; cben = 1'b0; cadr = 20'h00010; cwdata = 32'hDEADBEEF;
        @(negedge clk); // WR1
        checks++; if ({sr_we_n, sr_dout_en, sr_oe_n} !== 3'b111) begin errors++; $display("FAIL word_wr1_strobes got %b exp 111", {sr_we_n, sr_dout_en, sr_oe_n}); end
        checks++; if (sr_adr !== 18'd4) begin errors++; $display("FAIL word_wr1_adr got %h exp 4", sr_adr); end
        checks++; if (sr_be_n !== 4'b0000) begin errors++; $display("FAIL word_wr1_be_n got %b exp 0000", sr_be_n); end
        checks++; if (cack !== 1'b0) begin errors++; $display("FAIL word_wr1_cack got %b exp 0", cack); end
        @(negedge clk); // WR2
        checks++; if ({sr_we_n, sr_dout_en} !== 2'b01) begin errors++; $display("FAIL word_wr2_strobes got %b exp 01", {sr_we_n, sr_dout_en}); end
        checks++; if (sr_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL word_wr2_dout got %h exp deadbeef", sr_dout); end
        @(negedge clk); // ack cycle
        checks++; if ({cack, sr_we_n} !== 2'b11) begin errors++; $display("FAIL word_ack got cack/we_n %b exp 11", {cack, sr_we_n}); end
        cwr = 1'b0;
        exp_wr_word(4, 32'hDEADBEEF);
        fav_cpu = 1'b0;
        s = cyc;
        cpu_xfer(1'b0, 1'b0, 20'h00010, '0, rd, ack);
        checks++; if (ack - s !== 2) begin errors++; $display("FAIL word_rd_latency got %0d exp 2", ack - s); end
        checks++; if (rd !== exp_cpu_rd(4, 1'b0, 0)) begin errors++; $display("FAIL word_rd_data got %h exp %h", rd, exp_cpu_rd(4, 1'b0, 0)); end
    endtask

    task automatic test_cpu_byte();
        logic [31:0] rd; int ack;
        @(negedge clk);
        cwr = 1'b1; cben = 1'b1; cadr = 20'h00013; cwdata = 32'h1234565A;
        @(negedge clk); // WR1
        checks++; if (sr_be_n !== 4'b0111) begin errors++; $display("FAIL byte_be_n got %b exp 0111", sr_be_n); end
        checks++; if (sr_dout !== 32'h5A5A5A5A) begin errors++; $display("FAIL byte_dout got %h exp 5a5a5a5a", sr_dout); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (cack !== 1'b1) begin errors++; $display("FAIL byte_wr_ack got %b exp 1", cack); end
        cwr = 1'b0; cben = 1'b0;
        exp_wr_byte(4, 3, 8'h5A);
        cpu_xfer(1'b0, 1'b1, 20'h00013, '0, rd, ack);
        checks++; if (rd !== exp_cpu_rd(4, 1'b1, 3)) begin errors++; $display("FAIL byte_rd3 got %h exp %h", rd, exp_cpu_rd(4, 1'b1, 3)); end
        cpu_xfer(1'b0, 1'b1, 20'h00011, '0, rd, ack);
        checks++; if (rd !== exp_cpu_rd(4, 1'b1, 1)) begin errors++; $display("FAIL byte_rd1 got %h exp %h", rd, exp_cpu_rd(4, 1'b1, 1)); end
        cpu_xfer(1'b0, 1'b0, 20'h00010, '0, rd, ack);
        checks++; if (rd !== exp_cpu_rd(4, 1'b0, 0)) begin errors++; $display("FAIL byte_word_rd got %h exp %h", rd, exp_cpu_rd(4, 1'b0, 0)); end
    endtask

    task automatic test_contention();
        logic [31:0] vr, cr, dr; int va, ca, da, s, stall_n; bit stall_at_ack;
        do_reset();
        s = cyc; stall_n = 0; stall_at_ack = 1'b1;
        fork
            vid_xfer(18'd2, vr, va);
            cpu_xfer(1'b0, 1'b0, 20'(20 * 4), '0, cr, ca);
            dma_xfer(1'b0, 18'd33, '0, dr, da);
            begin
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (cack) begin stall_at_ack = cstall; break; end
                    if (cstall) stall_n++;
                end
            end
        join
        checks++; if (va - s !== 2) begin errors++; $display("FAIL cont_vack_cycle got %0d exp 2", va - s); end
        checks++; if (ca - s !== 3) begin errors++; $display("FAIL cont_cack_cycle got %0d exp 3", ca - s); end
        checks++; if (da - s !== 4) begin errors++; $display("FAIL cont_dack_cycle got %0d exp 4", da - s); end
        checks++; if (stall_n !== 2) begin errors++; $display("FAIL cont_stall_cycles got %0d exp 2", stall_n); end
        checks++; if (stall_at_ack !== 1'b0) begin errors++; $display("FAIL cont_stall_in_ack got %b exp 0", stall_at_ack); end
        checks++; if ({vr, cr, dr} !== {exp_rd(2), exp_rd(20), exp_rd(33)}) begin errors++; $display("FAIL cont_data got %h %h %h exp %h %h %h", vr, cr, dr, exp_rd(2), exp_rd(20), exp_rd(33)); end
        fav_cpu = 1'b1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            bit [2:0] m;
            bit c_wr, c_ben, d_wr;
            int va, ca, cl, da, s;
            logic [31:0] cwd, dwd, v_exp, c_exp, d_exp, v_got, c_got, d_got;
            int acks[3];
            bit wrs[3];
            int order[$];
            m = 3'($urandom_range(1, 7));
            c_wr = 1'($urandom); c_ben = 1'($urandom); d_wr = 1'($urandom);
            va = int'($urandom_range(0, 7));
            ca = int'($urandom_range(16, 31)); cl = int'($urandom_range(0, 3));
            da = int'($urandom_range(32, 47));
            cwd = $urandom; dwd = $urandom;
            wrs[0] = 1'b0; wrs[1] = c_wr; wrs[2] = d_wr;
            acks[0] = -1; acks[1] = -1; acks[2] = -1;
            v_exp = exp_rd(va);
            c_exp = '0; d_exp = '0;
            if (m[1]) begin
                if (!c_wr) c_exp = exp_cpu_rd(ca, c_ben, cl);
                else if (c_ben) exp_wr_byte(ca, cl, cwd[7:0]);
                else exp_wr_word(ca, cwd);
            end
            if (m[2]) begin
                if (!d_wr) d_exp = exp_rd(da);
                else exp_wr_word(da, dwd);
            end
            if (m[0]) order.push_back(0);
            if (m[1] && m[2]) begin
                if (fav_cpu) begin order.push_back(1); order.push_back(2); end
                else begin order.push_back(2); order.push_back(1); end
            end else if (m[1]) order.push_back(1);
            else if (m[2]) order.push_back(2);
            if (m[1] || m[2]) fav_cpu = (order[order.size() - 1] == 2);
            s = cyc;
            fork
                if (m[0]) vid_xfer(18'(va), v_got, acks[0]);
                if (m[1]) cpu_xfer(c_wr, c_ben, 20'(ca * 4 + cl), cwd, c_got, acks[1]);
                if (m[2]) dma_xfer(d_wr, 18'(da), dwd, d_got, acks[2]);
            join
            checks++; if (acks[order[0]] - s !== (wrs[order[0]] ? 3 : 2)) begin errors++; $display("FAIL rnd%0d_first_latency port %0d got %0d exp %0d", it, order[0], acks[order[0]] - s, wrs[order[0]] ? 3 : 2); end
            for (int k = 1; k < order.size(); k++) begin
                checks++; if (!(acks[order[k]] > acks[order[k-1]])) begin errors++; $display("FAIL rnd%0d_order port %0d ack %0d exp after port %0d ack %0d", it, order[k], acks[order[k]], order[k-1], acks[order[k-1]]); end
            end
            if (m[0]) begin checks++; if (v_got !== v_exp) begin errors++; $display("FAIL rnd%0d_vdata got %h exp %h", it, v_got, v_exp); end end
            if (m[1] && !c_wr) begin checks++; if (c_got !== c_exp) begin errors++; $display("FAIL rnd%0d_crdata got %h exp %h", it, c_got, c_exp); end end
            if (m[2] && !d_wr) begin checks++; if (d_got !== d_exp) begin errors++; $display("FAIL rnd%0d_drdata got %h exp %h", it, d_got, d_exp); end end
            @(negedge clk);
        end
    endtask

    task automatic test_fairness();
        int seq[$];
        int viol, nc, nd;
        bit first_cpu;
        first_cpu = fav_cpu; viol = 0; nc = 0; nd = 0;
        crd = 1'b1; cben = 1'b0; cadr = 20'(16 * 4);
        dreq = 1'b1; dwr = 1'b0; dadr = 18'd32;
        for (int i = 0; i < 100 && seq.size() < 20; i++) begin
            @(negedge clk);
            if (cack) begin seq.push_back(1); nc++; end
            if (dack) begin seq.push_back(2); nd++; end
        end
        crd = 1'b0; dreq = 1'b0;
        for (int k = 1; k < seq.size(); k++) if (seq[k] == seq[k-1]) viol++;
        checks++; if (seq.size() !== 20) begin errors++; $display("FAIL fair_acks got %0d exp 20", seq.size()); end
        if (seq.size() > 0) begin
            checks++; if (seq[0] !== (first_cpu ? 1 : 2)) begin errors++; $display("FAIL fair_first got %0d exp %0d", seq[0], first_cpu ? 1 : 2); end
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL fair_alternate repeats got %0d exp 0", viol); end
        checks++; if (nc !== nd) begin errors++; $display("FAIL fair_balance cpu %0d dma %0d exp equal", nc, nd); end
        checks++; if ({crdata, drdata} !== {exp_rd(16), exp_rd(32)}) begin errors++; $display("FAIL fair_data got %h %h exp %h %h", crdata, drdata, exp_rd(16), exp_rd(32)); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_turnaround();
        logic [31:0] wd;
        wd = $urandom;
        @(negedge clk);
        dreq = 1'b1; dwr = 1'b1; dadr = 18'd40; dwdata = wd;
        @(negedge clk); // WR1
        vreq = 1'b1; vadr = 18'd40;
        @(negedge clk); // WR2
        checks++; if ({sr_we_n, sr_dout_en} !== 2'b01) begin errors++; $display("FAIL turn_wr2 got %b exp 01", {sr_we_n, sr_dout_en}); end
        @(negedge clk); // turnaround IDLE
        checks++; if ({dack, sr_dout_en, sr_oe_n} !== 3'b101) begin errors++; $display("FAIL turn_idle dack/dout_en/oe_n got %b exp 101", {dack, sr_dout_en, sr_oe_n}); end
        dreq = 1'b0; dwr = 1'b0;
        exp_wr_word(40, wd);
        @(negedge clk); // video RD
        checks++; if ({sr_oe_n, sr_dout_en} !== 2'b00) begin errors++; $display("FAIL turn_rd got %b exp 00", {sr_oe_n, sr_dout_en}); end
        @(negedge clk);
        checks++; if (vack !== 1'b1 || vdata !== exp_rd(40)) begin errors++; $display("FAIL turn_vdata ack %b data %h exp 1 %h", vack, vdata, exp_rd(40)); end
        vreq = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [31:0] old;
        old = exp_rd(50);
        @(negedge clk);
        cwr = 1'b1; cben = 1'b0; cadr = 20'(50 * 4); cwdata = ~old;
        @(negedge clk); // WR1
        @(negedge clk); // WR2
        checks++; if (sr_we_n !== 1'b0) begin errors++; $display("FAIL ar_wr2_we_n got %b exp 0", sr_we_n); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({sr_we_n, sr_dout_en, sr_oe_n} !== 3'b101) begin errors++; $display("FAIL ar_strobes got %b exp 101", {sr_we_n, sr_dout_en, sr_oe_n}); end
        checks++; if ({cack, sr_be_n} !== 5'b01111) begin errors++; $display("FAIL ar_ack_be got %b exp 01111", {cack, sr_be_n}); end
        checks++; if (crdata !== 32'd0) begin errors++; $display("FAIL ar_crdata got %h exp 0", crdata); end
        cwr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        crd = 1'b1; cadr = 20'(50 * 4); rst = 1'b1;
        @(negedge clk);
        checks++; if ({sr_oe_n, sr_adr} !== {1'b0, 18'd50}) begin errors++; $display("FAIL ar_first_rd oe_n/adr got %b/%h exp 0/32", sr_oe_n, sr_adr); end
        @(negedge clk);
        checks++; if (cack !== 1'b1 || crdata !== old) begin errors++; $display("FAIL ar_first_data ack %b data %h exp 1 %h", cack, crdata, old); end
        crd = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            logic [31:0] v;
            v = $urandom;
            sram[i] = v;
            exp_mem[i] = v;
        end
        wr_tick++;
        test_reset();
        test_cpu_word();
        test_cpu_byte();
        test_contention();
        test_random();
        test_fairness();
        test_turnaround();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
